// File: rtl/mem_if_pkg.sv
// Shared constants and FSM state type for the cache refill/writeback line memory.
package mem_if_pkg;
    localparam int LINE_W     = 128;
    localparam int LINE_BYTES = 16;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_state_t;
endpackage

// File: rtl/line_store.sv
// Single-port synchronous line array: at most one write or one read per clock edge.
// The read register clears on reset or on request, so out-of-range reads can return zero.
module line_store #(
    parameter int W     = mem_if_pkg::LINE_W,
    parameter int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             clr,
    input  logic [IDX_W-1:0] idx,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata
);
    logic [W-1:0] lines [DEPTH];

    // Array contents survive reset on purpose; only the read register is reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lines[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= lines[idx];
        end
    end
endmodule

// File: rtl/line_mem_responder.sv
// Backing-memory responder: one whole-line read or write per request after a fixed latency.
// Optional macro LINE_MEM_OOR_CHECK_EN adds mem_err and rejects addresses beyond DEPTH lines.
module line_mem_responder #(
    parameter int LINE_W  = mem_if_pkg::LINE_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_req,
    input  logic                   WriteEnable,
    input  logic [31:0]            memory_address,
    input  logic [LINE_W-1:0]      mem_writedata,
    output logic [LINE_W-1:0]      mem_readdata,
    output logic                   mem_ready,
`ifdef LINE_MEM_OOR_CHECK_EN
    output logic                   mem_err,
`endif
    output mem_if_pkg::mem_state_t state
);
    import mem_if_pkg::*;

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [3:0]        cnt;
    logic              cap_we;
    logic [IDX_W-1:0]  cap_idx;
    logic [LINE_W-1:0] cap_wdata;
    logic              cap_oor;
    logic              err_q;
    logic              access;
    logic              unused_addr;

`ifdef LINE_MEM_OOR_CHECK_EN
    logic req_oor;
    assign req_oor     = |memory_address[31:OFF_W+IDX_W];
    assign unused_addr = ^memory_address[OFF_W-1:0];
    assign mem_err     = err_q;
`else
    logic req_oor;
    assign req_oor     = 1'b0;
    assign unused_addr = ^{memory_address[31:OFF_W+IDX_W], memory_address[OFF_W-1:0], err_q};
`endif

    // The array is touched only on the ACCESS->RESP edge, and never while reset is asserted.
    assign access = rst && (state == ACCESS) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_ready <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        cap_we    <= WriteEnable;
                        cap_idx   <= memory_address[OFF_W +: IDX_W];
                        cap_wdata <= mem_writedata;
                        cap_oor   <= req_oor;
                        cnt       <= CNT_INIT;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        mem_ready <= 1'b1;
                        err_q     <= cap_oor;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    line_store #(
        .W     (LINE_W),
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (clk),
        .rst   (rst),
        .wr_en (access && cap_we && !cap_oor),
        .rd_en (access && !cap_we && !cap_oor),
        .clr   (access && !cap_we && cap_oor),
        .idx   (cap_idx),
        .wdata (cap_wdata),
        .rdata (mem_readdata)
    );
endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized bench for line_mem_responder against an array-based line memory model.
// Honours LINE_MEM_OOR_CHECK_EN when the design is built with it.
module tb_line_mem_responder;
    import mem_if_pkg::*;

    localparam int LW    = 128;
    localparam int DEPTH = 256;
    localparam int LAT   = 4;
    localparam int IDX_W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_req = 1'b0;
    logic          WriteEnable = 1'b0;
    logic [31:0]   memory_address = '0;
    logic [LW-1:0] mem_writedata = '0;
    logic [LW-1:0] mem_readdata;
    logic          mem_ready;
    mem_state_t    state;
`ifdef LINE_MEM_OOR_CHECK_EN
    logic          mem_err;
`endif

    always #5 clk = ~clk;

    line_mem_responder #(
        .LINE_W  (LW),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .WriteEnable    (WriteEnable),
        .memory_address (memory_address),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .mem_ready      (mem_ready),
`ifdef LINE_MEM_OOR_CHECK_EN
        .mem_err        (mem_err),
`endif
        .state          (state)
    );

    logic [LW-1:0] model [DEPTH];
    logic [LW-1:0] last_rd;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit addr_oor(input logic [31:0] a);
`ifdef LINE_MEM_OOR_CHECK_EN
        return (a >> (4 + IDX_W)) != 32'd0;
`else
        return (a & 32'h0) != 32'd0;
`endif
    endfunction

    // Caller drives inputs right after a sampling point; exp_cycles counts edges to mem_ready.
    task automatic do_access(input bit we, input logic [31:0] a, input logic [LW-1:0] d,
                             input int exp_cycles, input bit keep_req, input string tag);
        int  n;
        bit  got;
        int  idx;
        bit  oor;
        logic [LW-1:0] exp;
        mem_req        = 1'b1;
        WriteEnable    = we;
        memory_address = a;
        mem_writedata  = d;
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_ready) begin
                got = 1'b1;
            end else if (n >= exp_cycles - LAT) begin
                // request already accepted: later input changes must be ignored
                memory_address = $urandom;
                mem_writedata  = rand_line();
                WriteEnable    = 1'($urandom_range(0, 1));
            end
        end
        check_eq({tag, " latency"}, LW'(n), LW'(exp_cycles));
        if (!got) begin
            mem_req = 1'b0;
            return;
        end
        idx = int'(a[4 +: IDX_W]);
        oor = addr_oor(a);
        if (we) begin
            if (!oor) model[idx] = d;
            check_eq({tag, " wr keeps rdata"}, mem_readdata, last_rd);
        end else begin
            exp = oor ? '0 : model[idx];
            check_eq({tag, " rdata"}, mem_readdata, exp);
            last_rd = exp;
        end
`ifdef LINE_MEM_OOR_CHECK_EN
        check_eq({tag, " err"}, LW'(mem_err), LW'(oor));
`endif
        if (!keep_req) begin
            mem_req = 1'b0;
            @(posedge clk);
            #1;
            check_eq({tag, " ready width"}, LW'(mem_ready), LW'(0));
        end
    endtask

    initial begin
        logic [31:0]   a;
        logic [LW-1:0] d;
        bit            held;
        bit            bad;

        // Reset held two edges with a pending request.
        rst = 1'b0; mem_req = 1'b1; WriteEnable = 1'b1; memory_address = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("reset ready", LW'(mem_ready), LW'(0));
        check_eq("reset rdata", mem_readdata, '0);
        check_eq("reset state", LW'(state), LW'(IDLE));
        mem_req = 1'b0;
        rst = 1'b1;
        last_rd = '0;
        @(posedge clk); #1;
        check_eq("idle state", LW'(state), LW'(IDLE));

        for (int i = 0; i < DEPTH; i++) begin
            do_access(1'b1, 32'(i) << 4, rand_line(), LAT + 1, 1'b0, "preload");
        end

        // Directed write then read of the same line via a different byte offset.
        do_access(1'b1, 32'h0000_0040, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF,
                  LAT + 1, 1'b0, "dir wr");
        do_access(1'b0, 32'h0000_004C, '0, LAT + 1, 1'b0, "dir rd");
        check_eq("dir rd value", mem_readdata, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);

        // Idle with no request: outputs hold.
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("idle hold ready", LW'(mem_ready), LW'(0));
            check_eq("idle hold rdata", mem_readdata, last_rd);
        end

        // Back-to-back: request held high through mem_ready.
        do_access(1'b1, 32'h0000_0100, rand_line(), LAT + 1, 1'b1, "b2b wr");
        do_access(1'b0, 32'h0000_0100, '0, LAT + 2, 1'b0, "b2b rd");

        // Reset during ACCESS of a write to line 3 aborts it.
        mem_req = 1'b1; WriteEnable = 1'b1; memory_address = 32'h30; mem_writedata = rand_line();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; mem_req = 1'b0;
        @(posedge clk); #1;
        check_eq("abort ready", LW'(mem_ready), LW'(0));
        check_eq("abort rdata", mem_readdata, '0);
        check_eq("abort state", LW'(state), LW'(IDLE));
        rst = 1'b1;
        last_rd = '0;
        bad = 1'b0;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (mem_ready) bad = 1'b1;
        end
        check_eq("abort no ready", LW'(bad), LW'(0));
        do_access(1'b0, 32'h30, '0, LAT + 1, 1'b0, "abort line3");

        // Address above the line range: aliases, or errors when the check is built in.
        do_access(1'b1, 32'h0001_0040, rand_line(), LAT + 1, 1'b0, "hi wr");
        do_access(1'b0, 32'h0000_0040, '0, LAT + 1, 1'b0, "hi line4");
        do_access(1'b0, 32'h0001_0040, '0, LAT + 1, 1'b0, "hi rd");

        // Random mix, with occasional back-to-back requests.
        held = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bit we;
            bit keep;
            we = 1'($urandom_range(0, 1));
            keep = ($urandom_range(0, 3) == 0);
`ifdef LINE_MEM_OOR_CHECK_EN
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
`else
            a = $urandom;
`endif
            d = rand_line();
            do_access(we, a, d, held ? LAT + 2 : LAT + 1, keep, "rand");
            held = keep;
        end
        if (held) begin
            mem_req = 1'b0;
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
